// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared macros, constants and helpers for the fetch PC generator (PC_ALIGN_CHECK_EN enables if_adef_o)
`ifndef LOONG_PC_START_ADDR
`define LOONG_PC_START_ADDR 32'h1c000000
`endif
`ifndef BrBusW
`define BrBusW (ADDR_W+1)
`endif
`ifndef RegW
`define RegW 32
`endif
package pc_gen_pkg;
  localparam int unsigned INSN_BYTES = 4;
  function automatic int unsigned grp_lsb(input int unsigned n);
    return n == 4 ? 4 : n == 2 ? 3 : 2;
  endfunction
endpackage

// File: rtl/pc_redirect_arb.sv
// pc_redirect_arb: fixed-priority pick of excp > jbr > pred redirect buses
`ifndef BrBusW
`define BrBusW (ADDR_W+1)
`endif
module pc_redirect_arb #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [`BrBusW-1:0] excp_bus_i,
  input  logic [`BrBusW-1:0] jbr_bus_i,
  input  logic [`BrBusW-1:0] pred_bus_i,
  output logic               redir_taken_o,
  output logic [ADDR_W-1:0]  redir_target_o
);
  assign redir_taken_o  = excp_bus_i[ADDR_W] | jbr_bus_i[ADDR_W] | pred_bus_i[ADDR_W];
  assign redir_target_o = excp_bus_i[ADDR_W] ? excp_bus_i[ADDR_W-1:0] :
                          jbr_bus_i[ADDR_W]  ? jbr_bus_i[ADDR_W-1:0]  : pred_bus_i[ADDR_W-1:0];
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with valid/ready handshake, slot mask and redirects; PC_ALIGN_CHECK_EN adds if_adef_o
`ifndef LOONG_PC_START_ADDR
`define LOONG_PC_START_ADDR 32'h1c000000
`endif
`ifndef BrBusW
`define BrBusW (ADDR_W+1)
`endif
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       FETCH_N  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = `LOONG_PC_START_ADDR
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [`BrBusW-1:0] excp_bus_i,
  input  logic [`BrBusW-1:0] jbr_bus_i,
  input  logic [`BrBusW-1:0] pred_bus_i,
  input  logic               if_ready_i,
  output logic               if_valid_o,
  output logic [ADDR_W-1:0]  if_pc_o,
  output logic [FETCH_N-1:0] if_slot_mask_o,
  output logic               if_redir_o
`ifdef PC_ALIGN_CHECK_EN
  ,output logic              if_adef_o
`endif
);
  localparam int unsigned G = grp_lsb(FETCH_N);
  logic [ADDR_W-1:0] pc, seq_pc, redir_target, slot;
  logic valid, redir, redir_taken, adef, fire;
  pc_redirect_arb #(.ADDR_W(ADDR_W)) u_arb (
    .excp_bus_i    (excp_bus_i),
    .jbr_bus_i     (jbr_bus_i),
    .pred_bus_i    (pred_bus_i),
    .redir_taken_o (redir_taken),
    .redir_target_o(redir_target)
  );
  assign fire   = valid & if_ready_i;
  assign seq_pc = ({pc[ADDR_W-1:G], {G{1'b0}}} + (ADDR_W'(1) << G)) | ADDR_W'(pc[1:0]);
  assign slot   = (pc >> 2) & ADDR_W'(FETCH_N - 1);
  assign if_valid_o = valid;
  assign if_pc_o    = pc;
  assign if_redir_o = redir;
  // slots at or after the addressed one are live; a misaligned PC exposes only its own slot
  always_comb begin
    if_slot_mask_o = '0;
    for (int i = 0; i < FETCH_N; i++) if_slot_mask_o[i] = adef ? slot == ADDR_W'(i) : slot <= ADDR_W'(i);
  end
  // PC update: redirect beats sequential advance; redirects before the first valid cycle are ignored
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc    <= RESET_PC;
      valid <= 1'b0;
      redir <= 1'b0;
    end else begin
      valid <= 1'b1;
      if (valid && redir_taken) begin
        pc    <= redir_target;
        redir <= 1'b1;
      end else if (fire) begin
        redir <= 1'b0;
        if (!adef) pc <= seq_pc;
      end
    end
  end
`ifdef PC_ALIGN_CHECK_EN
  assign if_adef_o = adef;
  // address fault flag tracks the alignment of the most recent redirect target
  always_ff @(posedge clk_i) begin
    if (rst_i) adef <= 1'b0;
    else if (valid && redir_taken) adef <= |redir_target[1:0];
  end
`else
  assign adef = 1'b0;
`endif
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised PC generation stage at the front of the fetch pipeline.
- Holds the fetch PC and presents it to IF with a valid/ready handshake.
- Supports multi-instruction fetch groups and a per-slot valid mask.
- Arbitrates three prioritised redirect sources: exception/ertn, EX branch, ID prediction.

Parameters:
- ADDR_W, 32, PC/address width in bits.
- FETCH_N, 1, instructions per fetch group; legal values 1, 2, 4.
- RESET_PC, `LOONG_PC_START_ADDR, PC value loaded on reset.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- excp_bus_i  in  ADDR_W+1  {taken, target}; exception/ertn redirect; highest priority.
- jbr_bus_i  in  ADDR_W+1  {taken, target}; EX-resolved branch redirect.
- pred_bus_i  in  ADDR_W+1  {taken, target}; ID-predicted redirect; lowest priority.
- if_ready_i  in  1  IF accepts the current PC.
- if_valid_o  out  1  if_pc_o is valid.
- if_pc_o  out  ADDR_W  current fetch PC.
- if_slot_mask_o  out  FETCH_N  valid instruction slots in the fetch group.
- if_redir_o  out  1  current PC was produced by a redirect.

Behaviour:
- Reset (rst_i=1 at posedge):
  - pc <= RESET_PC, if_valid_o <= 0, if_redir_o <= 0.
  - Overrides every input, including mid-stall or concurrent redirect.
- if_valid_o rises on the first posedge with rst_i=0 and stays 1 until the next reset.
- fire = if_valid_o & if_ready_i.
- Redirect priority: excp > jbr > pred. Only the winner's target is used; losers are dropped, not queued.
- Any redirect taken while if_valid_o=1 loads pc <= target at the next posedge, regardless of if_ready_i. A stalled PC is discarded.
- Redirects asserted while if_valid_o=0 (the first cycle after reset release) are ignored.
- Otherwise, if fire: pc <= seq_pc.
- Otherwise pc holds. if_pc_o, if_slot_mask_o and if_redir_o must stay stable while stalled.
- seq_pc arithmetic, with G = log2(FETCH_N)+2:
  - seq_pc[ADDR_W-1:G] = pc[ADDR_W-1:G] + 1.
  - seq_pc[G-1:2] = 0.
  - seq_pc[1:0] = pc[1:0].
  - Addition wraps modulo 2^ADDR_W (e.g. 0xFFFFFFFC -> 0x00000000 for FETCH_N=1).
- if_slot_mask_o:
  - Bit i = 1 iff i >= pc[G-1:2].
  - FETCH_N=1: constant 1'b1.
  - Reset value: all ones (pc=RESET_PC, group aligned).
- if_redir_o:
  - Registered; set with any redirect load, cleared on the next fire or reset.
  - Also set if a new redirect overrides a previous redirected PC.
- Latency: redirect to target on if_pc_o is 1 cycle. Output is combinational from registered state only; there is no input-to-output combinational path.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Adds output port if_adef_o (1 bit, reset 0).
  - On a redirect with target[1:0] != 0: pc loads the target as-is and if_adef_o <= 1.
  - While if_adef_o=1: sequential advance is frozen and if_valid_o stays 1. if_slot_mask_o reports only the addressed slot.
  - The flag clears only on the next redirect with an aligned target, or on reset.
- Undefined:
  - No port, no check; targets are used verbatim.

Decomposition:
- common.vh holds:
  - `LOONG_PC_START_ADDR.
  - Redirect bus width macro `BrBusW (= ADDR_W+1).
  - `RegW.
- Sub-module pc_redirect_arb: combinational 3-input priority selector producing {redir_taken, redir_target}. Reused later by the BTB-based predictor.

Test Plan:
- Reset release, FETCH_N=1, if_ready_i=1 constantly -> pc 0x1c000000, 0x1c000004, 0x1c000008; if_valid_o=1 from the first post-reset cycle.
- FETCH_N=4, jbr target 0x1c000018 -> if_pc_o=0x1c000018, mask=4'b1100, if_redir_o=1; next fire -> 0x1c000020, mask=4'b1111, if_redir_o=0.
- if_ready_i=0 for 3 cycles at pc 0x1c000010 -> pc, mask and redir stable; a jbr to 0x1c000100 during the stall -> pc=0x1c000100 next cycle.
- excp, jbr and pred all taken in the same cycle (targets 0x1c008000 / 0x1c000200 / 0x1c000300) -> pc=0x1c008000.
- pc=0xFFFFFFFC, FETCH_N=1, fire -> pc=0x00000000; rst_i asserted in the same cycle as an excp redirect -> pc=RESET_PC, if_valid_o=0.
- PC_ALIGN_CHECK_EN defined, pred target 0x1c000006 -> pc=0x1c000006, if_adef_o=1, pc frozen across fires; excp target 0x1c008000 -> if_adef_o=0.
